alu_result_writeback: RTL and testbench
=======================================

// Module: alu_result_writeback
// PURPOSE
//  Consumer end of the 16-bit ALU output interface: takes the packed 32-bit ALU result
//  ({hi,lo}) and N/Z/V flags from the EX/MEM boundary and sequences them into the
//  single-write-port register file and the architectural status-flag register.
//  SWAP (hi half valid) is split into two register writes over two cycles, with
//  back-pressure to the pipeline. Sits between the EX/MEM register and WB.
// PARAMETERS
//  DATA_W      16  width of one ALU half / register-file word
//  REG_ADDR_W  4   register-file address width
//  R0_IS_ZERO  1   1: writes to address 0 are suppressed (rf_we held 0)
// PORTS
//  clk         in   1             single clock, rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  in_valid    in   1             ALU result/flags/destinations valid
//  in_ready    out  1             block accepts this cycle (accept = in_valid & in_ready)
//  in_result   in   2*DATA_W      {hi,lo}; hi meaningful only for SWAP
//  in_op       in   3             ALU control code of the producing instruction
//  in_rd1      in   REG_ADDR_W    destination of lo half
//  in_rd2      in   REG_ADDR_W    destination of hi half (SWAP only)
//  in_n,in_z,in_v in 1 each       ALU Negative/Zero/Overflow
//  in_flag_we  in   1             instruction updates status flags
//  rf_we       out  1             register-file write enable (registered)
//  rf_waddr    out  REG_ADDR_W    write address (registered)
//  rf_wdata    out  DATA_W        write data (registered)
//  flags       out  3             status register {N,Z,V} (registered)
//  busy        out  1             SWAP high-half write pending next cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, flags=3'b000,
//   busy=0, held hi/rd2 cleared; in_ready=1 once state is IDLE. Any pending SWAP hi write is dropped.
//  FSM states: IDLE, WR_LO, WR_HI. Output regs drive rf_* during WR_LO/WR_HI.
//   any state, accept -> WR_LO (rf_we=1, waddr=in_rd1, wdata=in_result[DATA_W-1:0]).
//   WR_LO holding SWAP -> WR_HI (rf_we=1, waddr=held rd2, wdata=held hi half).
//   WR_LO/WR_HI with no accept and no pending hi -> IDLE (rf_we=0).
//  in_ready = !(state==WR_LO && held_op==SWAP); busy = !in_ready. Combinational from state.
//  Latency: write appears on rf_* in the cycle after accept; non-SWAP throughput 1/cycle,
//   SWAP occupies 2 cycles; an accept in WR_HI proceeds to WR_LO the next cycle (no bubble).
//  Flags: on accept with in_flag_we=1, flags <= {in_n,in_z,in_v}, visible same cycle as lo write;
//   in_flag_we=0 leaves flags unchanged. SWAP flags update once (on accept), never on hi write.
//  Opcodes 3'b110/3'b111 treated as OR (single write).
//  R0_IS_ZERO=1 and waddr==0: rf_we forced 0 for that write; FSM timing unchanged.
//  SWAP with in_rd1==in_rd2: both writes issued, hi (second) write is final value.
//  in_valid while in_ready=0: upstream holds all in_* stable; nothing captured.
//  rst_n asserted mid-SWAP: outputs clear immediately (async); hi write never issued.
// STRUCTURE
//  Shared package alu_pkg: ALU opcode localparams (ADD 000, SUB 001, MOVE 010, SWAP 011,
//   AND 100, OR 101), flag bit indices (N=2,Z=1,V=0), FSM state encoding.
//  Single module; no sub-module required (flag register is a 3-bit always block).
// TESTING
//  1 Reset: rst_n=0 mid-stream -> rf_we=0, flags=000, in_ready=1 without waiting for clk.
//  2 ADD rd1=3 result=32'h0000_0005 flag_we=1 n/z/v=000 -> next cycle rf_we=1, waddr=3,
//    wdata=16'h0005, flags=000; back-to-back SUB rd1=4 z=1 -> following cycle waddr=4, flags=010.
//  3 SWAP rd1=1 rd2=2 result=32'hAAAA_5555 -> cycle+1 waddr=1 wdata=5555, in_ready=0;
//    cycle+2 waddr=2 wdata=AAAA, in_ready=1; in_valid held during stall accepted only at cycle+2.
//  4 SWAP rd1=rd2=6 -> two writes to 6, last wdata=hi half; flags updated exactly once.
//  5 R0_IS_ZERO=1, MOVE rd1=0 -> rf_we stays 0, flags still update if flag_we=1.
//  6 rst_n pulse during WR_LO of SWAP -> no hi write ever observed; next ADD behaves per test 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, status-flag bit positions and the
// writeback sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MOVE = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } wb_state_e;

    // The two unassigned codes decode as OR, so they never start a two-write sequence.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op[2:1] == 2'b11) ? OP_OR : op;
    endfunction

endpackage

// File: rtl/alu_result_writeback.sv
// Sequences ALU results into the single-port register file and the status-flag
// register; SWAP is split into a lo write followed by a hi write.
module alu_result_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int R0_IS_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_W-1:0]     in_result,
    input  logic [2:0]              in_op,
    input  logic [REG_ADDR_W-1:0]   in_rd1,
    input  logic [REG_ADDR_W-1:0]   in_rd2,
    input  logic                    in_n,
    input  logic                    in_z,
    input  logic                    in_v,
    input  logic                    in_flag_we,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [2:0]              flags,
    output logic                    busy
);

    wb_state_e               state, state_nxt;
    logic [2:0]              held_op;
    logic [DATA_W-1:0]       held_hi;
    logic [REG_ADDR_W-1:0]   held_rd2;

    logic                    we_nxt;
    logic [REG_ADDR_W-1:0]   waddr_nxt;
    logic [DATA_W-1:0]       wdata_nxt;
    logic [2:0]              flags_nxt;
    logic                    hi_pending;
    logic                    accept;

    // Address 0 is a hardwired zero register when R0_IS_ZERO is set.
    function automatic logic wr_ok(input logic [REG_ADDR_W-1:0] addr);
        return (R0_IS_ZERO == 0) || (addr != '0);
    endfunction

    assign hi_pending = (state == ST_WR_LO) && (held_op == OP_SWAP);
    assign in_ready   = !hi_pending;
    assign busy       = hi_pending;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags    <= 3'b000;
        end else begin
            state    <= state_nxt;
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
            flags    <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        we_nxt    = 1'b0;
        waddr_nxt = rf_waddr;
        wdata_nxt = rf_wdata;
        flags_nxt = flags;
        if (accept) begin
            state_nxt = ST_WR_LO;
            we_nxt    = wr_ok(in_rd1);
            waddr_nxt = in_rd1;
            wdata_nxt = in_result[DATA_W-1:0];
            if (in_flag_we) begin
                flags_nxt[FLAG_N] = in_n;
                flags_nxt[FLAG_Z] = in_z;
                flags_nxt[FLAG_V] = in_v;
            end
        end else if (hi_pending) begin
            state_nxt = ST_WR_HI;
            we_nxt    = wr_ok(held_rd2);
            waddr_nxt = held_rd2;
            wdata_nxt = held_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_op  <= OP_ADD;
            held_hi  <= '0;
            held_rd2 <= '0;
        end else if (accept) begin
            held_op  <= norm_op(in_op);
            held_hi  <= in_result[2*DATA_W-1:DATA_W];
            held_rd2 <= in_rd2;
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed-vector bench for alu_result_writeback with hand-computed expectations.
module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_op;
    logic [3:0]  in_rd1;
    logic [3:0]  in_rd2;
    logic        in_n, in_z, in_v;
    logic        in_flag_we;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [2:0]  flags;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_writeback #(.DATA_W(16), .REG_ADDR_W(4), .R0_IS_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op),
        .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_n(in_n), .in_z(in_z), .in_v(in_v),
        .in_flag_we(in_flag_we),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags(flags), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] rd1, input logic [3:0] rd2,
                         input logic [31:0] res, input logic fwe, input logic [2:0] nzv);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd1     = rd1;
        in_rd2     = rd2;
        in_result  = res;
        in_flag_we = fwe;
        {in_n, in_z, in_v} = nzv;
    endtask

    task automatic wr(input string tag, input logic we, input logic [3:0] addr, input logic [15:0] data);
        check({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, "_waddr"}, 32'(rf_waddr), 32'(addr));
            check({tag, "_wdata"}, 32'(rf_wdata), 32'(data));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 3'b000; in_rd1 = 4'd0; in_rd2 = 4'd0;
        in_result = 32'h0; in_flag_we = 1'b0; {in_n, in_z, in_v} = 3'b000;

        // reset state
        #3;
        check("rst_we",    32'(rf_we),    32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", 32'(rf_wdata), 32'd0);
        check("rst_flags", 32'(flags),    32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        #14 rst_n = 1'b1;
        step();

        // ADD then back-to-back SUB
        drive(3'b000, 4'd3, 4'd0, 32'h0000_0005, 1'b1, 3'b000);
        step();
        wr("add", 1'b1, 4'd3, 16'h0005);
        check("add_flags", 32'(flags), 32'h0);
        check("add_ready", 32'(in_ready), 32'd1);
        drive(3'b001, 4'd4, 4'd0, 32'h0000_0000, 1'b1, 3'b010);
        step();
        wr("sub", 1'b1, 4'd4, 16'h0000);
        check("sub_flags", 32'(flags), 32'h2);
        in_valid = 1'b0;
        step();
        check("idle_we", 32'(rf_we), 32'd0);

        // SWAP with a stalled follower presented during the lo write
        drive(3'b011, 4'd1, 4'd2, 32'hAAAA_5555, 1'b1, 3'b100);
        step();
        wr("swap_lo", 1'b1, 4'd1, 16'h5555);
        check("swap_lo_ready", 32'(in_ready), 32'd0);
        check("swap_lo_busy",  32'(busy),     32'd1);
        check("swap_flags",    32'(flags),    32'h4);
        drive(3'b000, 4'd7, 4'd0, 32'h0000_0777, 1'b1, 3'b001);
        step();
        wr("swap_hi", 1'b1, 4'd2, 16'hAAAA);
        check("swap_hi_ready", 32'(in_ready), 32'd1);
        check("stall_flags",   32'(flags),    32'h4);
        step();
        wr("post_stall", 1'b1, 4'd7, 16'h0777);
        check("post_stall_flags", 32'(flags), 32'h1);
        in_valid = 1'b0;

        // SWAP to the same register twice; flags update only on accept
        drive(3'b011, 4'd6, 4'd6, 32'h1234_ABCD, 1'b1, 3'b011);
        step();
        in_valid = 1'b0;
        wr("same_lo", 1'b1, 4'd6, 16'hABCD);
        check("same_lo_flags", 32'(flags), 32'h3);
        {in_n, in_z, in_v} = 3'b100;
        step();
        wr("same_hi", 1'b1, 4'd6, 16'h1234);
        check("same_hi_flags", 32'(flags), 32'h3);
        step();
        check("same_end_we", 32'(rf_we), 32'd0);

        // R0 suppression, OR-alias opcode, SWAP hi to R0
        drive(3'b010, 4'd0, 4'd0, 32'h0000_BEEF, 1'b1, 3'b110);
        step();
        check("r0_we",    32'(rf_we),    32'd0);
        check("r0_flags", 32'(flags),    32'h6);
        check("r0_ready", 32'(in_ready), 32'd1);
        drive(3'b111, 4'd9, 4'd3, 32'hFFFF_0F0F, 1'b0, 3'b000);
        step();
        in_valid = 1'b0;
        wr("op7", 1'b1, 4'd9, 16'h0F0F);
        check("op7_ready", 32'(in_ready), 32'd1);
        check("op7_flags", 32'(flags),    32'h6);
        step();
        check("op7_single", 32'(rf_we), 32'd0);
        drive(3'b011, 4'd5, 4'd0, 32'h1111_2222, 1'b0, 3'b000);
        step();
        in_valid = 1'b0;
        wr("swr0_lo", 1'b1, 4'd5, 16'h2222);
        check("swr0_ready", 32'(in_ready), 32'd0);
        step();
        check("swr0_hi_we",    32'(rf_we),    32'd0);
        check("swr0_hi_ready", 32'(in_ready), 32'd1);

        // async reset during the lo write of a SWAP
        drive(3'b011, 4'd1, 4'd2, 32'hCCCC_3333, 1'b1, 3'b111);
        step();
        in_valid = 1'b0;
        wr("ar_lo", 1'b1, 4'd1, 16'h3333);
        #2 rst_n = 1'b0;
        #1;
        check("ar_we",    32'(rf_we),    32'd0);
        check("ar_flags", 32'(flags),    32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        check("ar_busy",  32'(busy),     32'd0);
        check("ar_waddr", 32'(rf_waddr), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("ar_nohi1", 32'(rf_we), 32'd0);
        step();
        check("ar_nohi2", 32'(rf_we), 32'd0);
        drive(3'b000, 4'd3, 4'd0, 32'h0000_0005, 1'b1, 3'b000);
        step();
        in_valid = 1'b0;
        wr("ar_add", 1'b1, 4'd3, 16'h0005);
        check("ar_add_flags", 32'(flags), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
